// File: rtl/prog_timer.sv
// prog_timer -- programmable tick generator.
//
// Counts steps in RUN and emits a registered one-cycle TICK each time the
// count reaches the programmed period. Periodic mode (MODE=0) keeps running;
// one-shot mode (MODE=1) parks in EXPIRED with DONE high until re-started.
//
// Optional feature: define TIMER_PRESCALER_EN to insert a PRESCALE-cycle
// prescaler so that one step takes PRESCALE enabled RUN cycles.
//
// Ports
//   CLK        in   1      clock, posedge
//   RES        in   1      asynchronous active-high reset
//   EN         in   1      step enable; low freezes counter and prescaler
//   START      in   1      level; IDLE/EXPIRED/RUN -> RUN with COUNT=0
//   STOP       in   1      level; any state -> IDLE with COUNT=0 (wins over START)
//   LOAD       in   1      capture PERIOD into period_q (0 is stored as 1)
//   PERIOD     in   WIDTH  new period in steps
//   MODE       in   1      0 = periodic, 1 = one-shot; sampled at each wrap
//   TICK       out  1      one-cycle pulse per expiry, registered
//   DONE       out  1      high in EXPIRED
//   BUSY       out  1      high in RUN
//   COUNT      out  WIDTH  current count
//   DBG_STATE  out  2      current FSM state (debug visibility only)
//
// Control handshake: START/STOP/LOAD are plain levels sampled on every
// rising CLK edge; there is no valid/ready pairing, each asserted cycle acts.

module prog_timer #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DEFAULT_PERIOD = 500000000,
    parameter int unsigned PRESCALE       = 1
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             EN,
    input  logic             START,
    input  logic             STOP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] PERIOD,
    input  logic             MODE,
    output logic             TICK,
    output logic             DONE,
    output logic             BUSY,
    output logic [WIDTH-1:0] COUNT,
    output logic [1:0]       DBG_STATE
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    // Reset period, truncated to WIDTH; a zero period would never wrap, so it becomes 1.
    localparam logic [WIDTH-1:0] DEF_TRUNC  = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] DEF_PERIOD = (DEF_TRUNC == '0) ? WIDTH'(1) : DEF_TRUNC;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             tick_q, tick_d;
    logic             step;
    logic             wrap;

`ifdef TIMER_PRESCALER_EN
    localparam int unsigned PS_EFF = (PRESCALE == 0) ? 1 : PRESCALE;
    localparam int unsigned PS_W   = (PS_EFF > 1) ? $clog2(PS_EFF) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PS_EFF - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    // The prescaler only advances on enabled RUN cycles; a step fires on its
    // last phase and it returns to 0. START/STOP re-align it.
    always_comb begin
        ps_d = ps_q;
        step = 1'b0;
        if (STOP || START) begin
            ps_d = '0;
        end else if (state_q == S_RUN && EN) begin
            if (ps_q == PS_LAST) begin
                ps_d = '0;
                step = 1'b1;
            end else begin
                ps_d = ps_q + PS_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    logic unused_prescale;
    assign unused_prescale = (PRESCALE == 0);
    assign step = (state_q == S_RUN) && EN;
`endif

    // Wrap when the current count has reached the last value of the period.
    // period_q is never 0, so the subtraction cannot underflow.
    assign wrap = (count_q >= (period_q - WIDTH'(1)));

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tick_d   = 1'b0;
        period_d = period_q;

        // A wrap on the same edge as LOAD still compares with the old period_q.
        if (LOAD) begin
            period_d = (PERIOD == '0) ? WIDTH'(1) : PERIOD;
        end

        if (STOP) begin
            state_d = S_IDLE;
            count_d = '0;
        end else if (START) begin
            state_d = S_RUN;
            count_d = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (step) begin
                        if (wrap) begin
                            count_d = '0;
                            tick_d  = 1'b1;
                            if (MODE) begin
                                state_d = S_EXPIRED;
                            end
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end
                end
                S_EXPIRED: begin
                    count_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            period_q <= DEF_PERIOD;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            tick_q   <= tick_d;
        end
    end

    assign TICK      = tick_q;
    assign DONE      = (state_q == S_EXPIRED);
    assign BUSY      = (state_q == S_RUN);
    assign COUNT     = count_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_prog_timer.sv
// Bench for prog_timer: directed sequences with literal expectations plus a
// long randomized run, all checked every cycle against a step-level model.

module tb_prog_timer;
  localparam int W = 8;
  localparam int DEF_P = 4;
`ifdef TIMER_PRESCALER_EN
  localparam int PS = 3;
`else
  localparam int PS = 1;
`endif

  logic         CLK = 1'b0;
  logic         RES = 1'b1;
  logic         EN = 1'b0;
  logic         START = 1'b0;
  logic         STOP = 1'b0;
  logic         LOAD = 1'b0;
  logic [W-1:0] PERIOD = '0;
  logic         MODE = 1'b0;
  logic         TICK;
  logic         DONE;
  logic         BUSY;
  logic [W-1:0] COUNT;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  prog_timer #(.WIDTH(W), .DEFAULT_PERIOD(DEF_P), .PRESCALE(PS)) dut (
    .CLK(CLK), .RES(RES), .EN(EN), .START(START), .STOP(STOP), .LOAD(LOAD),
    .PERIOD(PERIOD), .MODE(MODE), .TICK(TICK), .DONE(DONE), .BUSY(BUSY),
    .COUNT(COUNT), .DBG_STATE(dbg_state)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // Timer described in terms of "running", "expired", steps and a period.
  bit m_run, m_exp, m_tick;
  int m_count, m_period, m_phase;

  always @(posedge CLK or posedge RES) begin
    if (RES) begin
      m_run <= 1'b0; m_exp <= 1'b0; m_tick <= 1'b0;
      m_count <= 0; m_period <= DEF_P; m_phase <= 0;
    end else begin
      if (LOAD) m_period <= (PERIOD == 0) ? 1 : int'(PERIOD);
      m_tick <= 1'b0;
      if (STOP) begin
        m_run <= 1'b0; m_exp <= 1'b0; m_count <= 0; m_phase <= 0;
      end else if (START) begin
        m_run <= 1'b1; m_exp <= 1'b0; m_count <= 0; m_phase <= 0;
      end else if (m_run && EN) begin
        if (m_phase + 1 < PS) begin
          m_phase <= m_phase + 1;
        end else begin
          m_phase <= 0;
          if (m_count + 1 >= m_period) begin
            m_count <= 0;
            m_tick <= 1'b1;
            if (MODE) begin
              m_run <= 1'b0; m_exp <= 1'b1;
            end
          end else begin
            m_count <= m_count + 1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_tick", int'(TICK), int'(m_tick));
      chk("model_done", int'(DONE), int'(m_exp));
      chk("model_busy", int'(BUSY), int'(m_run));
      chk("model_count", int'(COUNT), m_count);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic idle_inputs();
    START = 1'b0; STOP = 1'b0; LOAD = 1'b0;
  endtask

  task automatic do_reset();
    RES = 1'b1;
    cyc(2);
    RES = 1'b0;
  endtask

  task automatic start_with(input int per, input bit mode);
    if (per >= 0) begin LOAD = 1'b1; PERIOD = W'(per); end
    MODE = mode; EN = 1'b1; START = 1'b1;
    cyc(1);
    idle_inputs();
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("reset_tick", int'(TICK), 0);
    chk("reset_done", int'(DONE), 0);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_count", int'(COUNT), 0);

`ifndef TIMER_PRESCALER_EN
    // periodic with default period 4: TICK after edges 4 and 8
    start_with(-1, 1'b0);
    chk("start_busy", int'(BUSY), 1);
    chk("start_count", int'(COUNT), 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      chk("per_tick", int'(TICK), (i % 4 == 0) ? 1 : 0);
      chk("per_count", int'(COUNT), i % 4);
      chk("per_done", int'(DONE), 0);
    end

    // one-shot
    start_with(-1, 1'b1);
    cyc(4);
    chk("os_tick", int'(TICK), 1);
    chk("os_done", int'(DONE), 1);
    chk("os_busy", int'(BUSY), 0);
    cyc(2);
    chk("os_tick_once", int'(TICK), 0);
    chk("os_done_sticky", int'(DONE), 1);
    chk("os_count_hold", int'(COUNT), 0);
    start_with(-1, 1'b1);
    chk("os_rearm_done", int'(DONE), 0);
    chk("os_rearm_busy", int'(BUSY), 1);

    // LOAD a shorter period while COUNT=6 of 10
    start_with(10, 1'b0);
    cyc(6);
    chk("ld_count6", int'(COUNT), 6);
    LOAD = 1'b1; PERIOD = 8'd3;
    cyc(1);
    LOAD = 1'b0;
    chk("ld_old_period", int'(COUNT), 7);
    chk("ld_no_tick_yet", int'(TICK), 0);
    cyc(1);
    chk("ld_wrap_tick", int'(TICK), 1);
    chk("ld_wrap_count", int'(COUNT), 0);

    // EN gating at COUNT=2
    start_with(4, 1'b0);
    cyc(2);
    EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("en_hold_count", int'(COUNT), 2);
      chk("en_hold_tick", int'(TICK), 0);
    end
    EN = 1'b1;
    cyc(1);
    chk("en_resume_count", int'(COUNT), 3);
    chk("en_resume_tick", int'(TICK), 0);
    cyc(1);
    chk("en_resume_wrap", int'(TICK), 1);

    // START and STOP together
    START = 1'b1; STOP = 1'b1;
    cyc(1);
    idle_inputs();
    chk("ss_busy", int'(BUSY), 0);
    chk("ss_count", int'(COUNT), 0);

    // reset mid-run at COUNT=3
    start_with(8, 1'b0);
    cyc(3);
    chk("rst_pre_count", int'(COUNT), 3);
    RES = 1'b1;
    #1;
    chk("rst_tick", int'(TICK), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_count", int'(COUNT), 0);
    cyc(2);
    RES = 1'b0;
    cyc(1);
    chk("rst_after_tick", int'(TICK), 0);

    // period 1: TICK continuously high in periodic mode
    start_with(1, 1'b0);
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      chk("p1_tick", int'(TICK), 1);
      cyc(1);
    end
`else
    start_with(-1, 1'b0);
    for (int i = 1; i <= 24; i++) begin
      cyc(1);
      chk("ps_tick12", int'(TICK), (i % 12 == 0) ? 1 : 0);
    end
    start_with(0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      cyc(1);
      chk("ps_tick3", int'(TICK), (i % 3 == 0) ? 1 : 0);
    end
`endif

    // randomized run, checked by the model every cycle
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int r;
      RES   = ($urandom_range(0, 999) < 4);
      STOP  = ($urandom_range(0, 99) < 2);
      START = ($urandom_range(0, 99) < 4);
      EN    = ($urandom_range(0, 99) < 85);
      MODE  = ($urandom_range(0, 99) < 25);
      LOAD  = ($urandom_range(0, 99) < 5);
      r = $urandom_range(0, 99);
      if (r < 90) PERIOD = W'($urandom_range(0, 12));
      else if (r < 95) PERIOD = 8'd255;
      else PERIOD = W'($urandom_range(0, 255));
      cyc(1);
      if (RES) begin
        RES = 1'b0;
        cyc(1);
      end
    end
    idle_inputs();
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
